clock_divider_multi: RTL
========================

# clock_divider_multi

Multi-channel programmable clock divider, the parametrised successor to the fixed single-ratio divider. Each of NUM_CH channels divides clk_i by a runtime-loadable integer ratio D (2..2^DIV_W-1), supporting both even and odd D. Ratio changes are shadowed and applied only at a period boundary, so outputs never glitch. The block sits in the clock/timer subsystem and drives enable-style divided clocks plus single-cycle edge strobes to downstream synchronous logic in the clk_i domain.

## Interface
- NUM_CH, 4, number of independent divider channels (>=1)
- DIV_W, 8, width of each divide ratio (>=2)
- DEFAULT_DIV, 2, ratio loaded into every channel at reset (2..2^DIV_W-1)

- clk_i  in  1  source clock
- rst_ni  in  1  asynchronous, active-low reset
- enable_i  in  NUM_CH  per-channel count enable; 0 freezes that channel
- div_i  in  NUM_CH*DIV_W  per-channel requested ratio; channel c uses bits [c*DIV_W +: DIV_W]
- load_i  in  NUM_CH  per-channel single-cycle strobe capturing div_i slice
- sync_i  in  1  restart all channels in phase
- err_clr_i  in  1  clears all cfg_err_o bits
- clk_div_o  out  NUM_CH  divided clock, registered
- rise_o  out  NUM_CH  one-cycle strobe, high in the cycle clk_div_o first reads 1 for a period
- fall_o  out  NUM_CH  one-cycle strobe, high in the cycle clk_div_o first reads 0 for a period
- cfg_err_o  out  NUM_CH  sticky: illegal ratio (<2) was loaded

## Operation
- Per channel state: active ratio act (DIV_W), pending ratio pend plus pend_vld, counter cnt (DIV_W), output flop.
- Reset: act=DEFAULT_DIV, pend_vld=0, cnt=0; clk_div_o, rise_o, fall_o, cfg_err_o all 0.
- Phase split: L = floor(act/2) low cycles, then act-L high cycles (odd D is high one cycle longer than low).
- Enabled edge: cnt_next = (cnt==act-1) ? 0 : cnt+1; clk_div_o <= (cnt_next >= L); rise_o <= (cnt_next == L); fall_o <= (cnt_next == 0).
- Disabled edge: cnt and clk_div_o hold; rise_o and fall_o are 0; pending ratio is not applied.
- Load with div_i slice >= 2: pend <= value, pend_vld <= 1. A later load before the boundary overwrites pend.
- Load with div_i slice < 2: cfg_err_o[c] <= 1; pend, pend_vld, and act are unchanged.
- Boundary (enabled edge with cnt==act-1): if pend_vld, act <= pend and pend_vld <= 0. L for the new period is derived from the new act.
- Legal load in the same cycle as a boundary: the loaded value becomes act directly at that boundary, and pend_vld is cleared.
- sync_i (priority over enable_i and normal counting): every channel takes cnt <= 0, clk_div_o <= 0, rise_o <= 0, fall_o <= 0. Any pending ratio is applied immediately (act <= pend, pend_vld <= 0). A legal load_i in the same cycle is applied directly to act.
- err_clr_i clears cfg_err_o. If an illegal load occurs in the same cycle, the set wins.
- Channels are fully independent except for sync_i and err_clr_i.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- After reset release with enable high and D=DEFAULT_DIV: clk_div_o stays low for L cycles (the reset cycle counts as cnt=0), then high for D-L cycles, with period D.
- rise_o and fall_o are coincident with the clk_div_o transition they mark.
- Ratio change latency: the new ratio takes effect from the first cycle after the current period's final cycle. No truncated or stretched high or low phase occurs.
- sync_i: in the cycle after sync_i, cnt=0 and clk_div_o=0 on all channels. The first rise occurs L enabled edges later.
- Disabling mid-period stretches the current phase by the disabled cycle count. Re-enabling resumes from the held cnt.
- Counter arithmetic is DIV_W bits unsigned. cnt < act always holds, so cnt never wraps.

## Test plan
- Reset, enable all channels, DEFAULT_DIV=2 -> clk_div_o toggles every cycle. rise_o and fall_o alternate each cycle, starting with rise_o on the 2nd cycle after reset release.
- Load D=3 on ch0 and D=8 on ch1, then sync_i -> ch0 pattern is low 1, high 2 (period 3). ch1 pattern is low 4, high 4. Exactly one rise_o and one fall_o per period.
- ch0 running D=4; load D=5 mid-period at cnt=1 -> current period completes at 4 cycles, and the following periods are 5 (low 2, high 3). No extra strobes.
- Load div_i=0 then 1 on ch2 -> cfg_err_o[2]=1 and ratio unchanged. err_clr_i -> 0. err_clr_i in the same cycle as an illegal load -> cfg_err_o stays 1.
- Deassert enable_i[1] for 3 cycles mid-high phase with D=6 -> that high phase lasts 6 cycles and no strobes occur while disabled. Other channels are unaffected.
- Assert rst_ni low mid-period -> all outputs 0 immediately. After release, channels run at DEFAULT_DIV regardless of the previously loaded ratio.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with shadowed ratio updates.
// Each channel produces a registered divided clock plus rise/fall strobes.
module clock_divider_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       enable_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       load_i,
    input  logic                    sync_i,
    input  logic                    err_clr_i,
    output logic [NUM_CH-1:0]       clk_div_o,
    output logic [NUM_CH-1:0]       rise_o,
    output logic [NUM_CH-1:0]       fall_o,
    output logic [NUM_CH-1:0]       cfg_err_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] act_q;
        logic [DIV_W-1:0] pend_q;
        logic             pend_vld_q;
        logic [DIV_W-1:0] cnt_q;
        logic             clk_q;
        logic             rise_q;
        logic             fall_q;
        logic             err_q;

        logic [DIV_W-1:0] req;
        logic [DIV_W-1:0] cnt_nxt;
        logic [DIV_W-1:0] half;
        logic             legal;
        logic             illegal;
        logic             wrap;

        assign req     = div_i[c*DIV_W +: DIV_W];
        assign legal   = load_i[c] && (req >= DIV_W'(2));
        assign illegal = load_i[c] && (req < DIV_W'(2));
        assign wrap    = (cnt_q == act_q - DIV_W'(1));
        assign cnt_nxt = wrap ? '0 : cnt_q + DIV_W'(1);
        // Low phase is the shorter half, so odd ratios stay high one extra cycle.
        assign half    = act_q >> 1;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                act_q      <= DIV_W'(DEFAULT_DIV);
                pend_q     <= '0;
                pend_vld_q <= 1'b0;
                cnt_q      <= '0;
                clk_q      <= 1'b0;
                rise_q     <= 1'b0;
                fall_q     <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                if (sync_i) begin
                    cnt_q      <= '0;
                    clk_q      <= 1'b0;
                    rise_q     <= 1'b0;
                    fall_q     <= 1'b0;
                    pend_vld_q <= 1'b0;
                    if (legal) begin
                        act_q <= req;
                    end else if (pend_vld_q) begin
                        act_q <= pend_q;
                    end
                end else begin
                    if (enable_i[c]) begin
                        cnt_q  <= cnt_nxt;
                        clk_q  <= (cnt_nxt >= half);
                        rise_q <= (cnt_nxt == half);
                        fall_q <= (cnt_nxt == '0);
                    end else begin
                        rise_q <= 1'b0;
                        fall_q <= 1'b0;
                    end
                    // Ratio swaps only on the last cycle of a period.
                    if (enable_i[c] && wrap) begin
                        pend_vld_q <= 1'b0;
                        if (legal) begin
                            act_q <= req;
                        end else if (pend_vld_q) begin
                            act_q <= pend_q;
                        end
                    end else if (legal) begin
                        pend_q     <= req;
                        pend_vld_q <= 1'b1;
                    end
                end
                if (illegal) begin
                    err_q <= 1'b1;
                end else if (err_clr_i) begin
                    err_q <= 1'b0;
                end
            end
        end

        assign clk_div_o[c] = clk_q;
        assign rise_o[c]    = rise_q;
        assign fall_o[c]    = fall_q;
        assign cfg_err_o[c] = err_q;
    end

endmodule
